instr_fetch_unit: RTL and testbench

// - Fetch stage ahead of the opcode/func decoder: holds PC, reads instruction memory via req/ready handshake.
// - Latches the word into IR and presents op_code/func_code/register/immediate fields with a valid/ready handshake.
// - Updates PC on acceptance: sequential step, branch target, or register target (reg_to_PC path). Stops on HALT opcode.

---
 rtl/instr_fetch_unit_pkg.sv | 34 +++
 rtl/instr_fetch_unit_pc_next_sel.sv | 33 +++
 rtl/instr_fetch_unit.sv | 102 ++++++++++
 tb/tb_instr_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcodes, IR field layout,
// FSM state encoding and small IR decode helpers.
package instr_fetch_unit_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'd0;
  localparam logic [5:0] OPC_J     = 6'd2;
  localparam logic [5:0] OPC_BEQ   = 6'd4;
  localparam logic [5:0] OPC_ADDI  = 6'd8;
  localparam logic [5:0] OPC_LW    = 6'd35;
  localparam logic [5:0] OPC_SW    = 6'd43;
  localparam logic [5:0] OPC_HALT  = 6'd63;

  localparam int IR_OP_MSB   = 31;
  localparam int IR_OP_LSB   = 26;
  localparam int IR_RS_MSB   = 25;
  localparam int IR_RS_LSB   = 21;
  localparam int IR_RT_MSB   = 20;
  localparam int IR_RT_LSB   = 16;
  localparam int IR_IMM_MSB  = 15;
  localparam int IR_IMM_LSB  = 0;
  localparam int IR_FUNC_MSB = 10;
  localparam int IR_FUNC_LSB = 0;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  function automatic logic [5:0] ir_opcode(input logic [31:0] ir);
    return ir[IR_OP_MSB:IR_OP_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// Next-PC selection: register target beats branch target beats sequential step.
// Redirect targets are forced onto an instruction boundary.
import instr_fetch_unit_pkg::*;

module instr_fetch_unit_pc_next_sel #(
  parameter int          ADDR_W  = 32,
  parameter int unsigned PC_STEP = 4
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_reg_to_pc,
  input  logic [ADDR_W-1:0] i_reg_target,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  output logic [ADDR_W-1:0] o_pc_next
);

  // PC_STEP is a power of two, so clearing its low bits aligns a target.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(PC_STEP - 1));

  logic [ADDR_W-1:0] w_pc_seq;

  assign w_pc_seq = i_pc + ADDR_W'(PC_STEP);

  always_comb begin
    o_pc_next = w_pc_seq;
    if (i_reg_to_pc) begin
      o_pc_next = i_reg_target & ALIGN_MASK;
    end else if (i_branch_taken) begin
      o_pc_next = i_branch_target & ALIGN_MASK;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: walks IDLE/FETCH/WAIT/ISSUE, captures the instruction word into IR,
// hands decoded fields downstream and picks the next PC when the word is accepted.
import instr_fetch_unit_pkg::*;

module instr_fetch_unit #(
  parameter int                ADDR_W      = 32,
  parameter int unsigned       PC_STEP     = 4,
  parameter logic [5:0]        HALT_OPCODE = OPC_HALT,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ready,
  input  logic [31:0]       i_imem_rdata,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  output logic [5:0]        o_op_code,
  output logic [10:0]       o_func_code,
  output logic [4:0]        o_rs,
  output logic [4:0]        o_rt,
  output logic [15:0]       o_imm,
  output logic [ADDR_W-1:0] o_pc_out,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_reg_to_pc,
  input  logic [ADDR_W-1:0] i_reg_target,
  output logic              o_halted
);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic [ADDR_W-1:0] r_pc_out;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_accept;
  logic              w_is_halt;

  instr_fetch_unit_pc_next_sel #(
    .ADDR_W  (ADDR_W),
    .PC_STEP (PC_STEP)
  ) u_pc_next_sel (
    .i_pc            (r_pc),
    .i_reg_to_pc     (i_reg_to_pc),
    .i_reg_target    (i_reg_target),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .o_pc_next       (w_pc_next)
  );

  assign w_accept  = (r_state == ST_ISSUE) && i_instr_ready;
  assign w_is_halt = (ir_opcode(r_ir) == HALT_OPCODE);

  // imem_ready is only honoured in WAIT, so a response arriving after reset is dropped.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_pc_out <= '0;
    end else begin
      case (r_state)
        ST_IDLE:  r_state <= ST_FETCH;
        ST_FETCH: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (i_imem_ready) begin
            r_ir     <= i_imem_rdata;
            r_pc_out <= r_pc;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_accept) begin
            if (w_is_halt) begin
              r_state <= ST_HALTED;
            end else begin
              r_pc    <= w_pc_next;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs decode state only, keeping them free of input paths.
  assign o_imem_req    = (r_state == ST_FETCH) || (r_state == ST_WAIT);
  assign o_imem_addr   = r_pc;
  assign o_instr_valid = (r_state == ST_ISSUE);
  assign o_halted      = (r_state == ST_HALTED);

  assign o_op_code   = r_ir[IR_OP_MSB:IR_OP_LSB];
  assign o_func_code = r_ir[IR_FUNC_MSB:IR_FUNC_LSB];
  assign o_rs        = r_ir[IR_RS_MSB:IR_RS_LSB];
  assign o_rt        = r_ir[IR_RT_MSB:IR_RT_LSB];
  assign o_imm       = r_ir[IR_IMM_MSB:IR_IMM_LSB];
  assign o_pc_out    = r_pc_out;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: a memory responder predicts each
// fetched word, a monitor checks it on issue and advances a reference PC model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady = 1'b0;
  logic [31:0] imemRdata = '0;
  logic        instrValid;
  logic        instrReady = 1'b0;
  logic [5:0]  opCode;
  logic [10:0] funcCode;
  logic [4:0]  rsOut;
  logic [4:0]  rtOut;
  logic [15:0] immOut;
  logic [31:0] pcOut;
  logic        branchTaken = 1'b0;
  logic [31:0] branchTarget = '0;
  logic        regToPc = 1'b0;
  logic [31:0] regTarget = '0;
  logic        halted;

  instr_fetch_unit dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .o_imem_req      (imemReq),
    .o_imem_addr     (imemAddr),
    .i_imem_ready    (imemReady),
    .i_imem_rdata    (imemRdata),
    .o_instr_valid   (instrValid),
    .i_instr_ready   (instrReady),
    .o_op_code       (opCode),
    .o_func_code     (funcCode),
    .o_rs            (rsOut),
    .o_rt            (rtOut),
    .o_imm           (immOut),
    .o_pc_out        (pcOut),
    .i_branch_taken  (branchTaken),
    .i_branch_target (branchTarget),
    .i_reg_to_pc     (regToPc),
    .i_reg_target    (regTarget),
    .o_halted        (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } expT;

  typedef struct {
    bit          useReg;
    bit          useBr;
    logic [31:0] regT;
    logic [31:0] brT;
  } redirT;

  int          checks = 0;
  int          passes = 0;
  expT         expQ[$];
  redirT       plan[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] modelPc = '0;
  bit          modelHalted = 1'b0;
  bit          haltArmed = 1'b0;
  logic [31:0] haltAddr = 32'h0000_0200;
  int          forceDelay = -1;
  int          forceStall = 0;
  bit          holdMem = 1'b0;
  int          accepts = 0;
  int          reqCycles = 0;
  int          respDelay = 0;
  bit          served = 1'b0;
  logic [31:0] firstAddr = '0;
  int          validCycles = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
  endtask

  // Memory contents are generated lazily; only the armed halt address holds HALT.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    logic [31:0] w;
    if (haltArmed && addr == haltAddr) return 32'hFC00_0000;
    if (!mem.exists(addr)) begin
      w = $urandom;
      if (w[31:26] == 6'd63) w[31:26] = 6'd35;
      mem[addr] = w;
    end
    return mem[addr];
  endfunction

  function automatic logic [31:0] alignDown(input logic [31:0] t);
    return (t / 4) * 4;
  endfunction

  function automatic logic [31:0] refNextPc(input logic [31:0] pc, input redirT r);
    if (r.useReg) return alignDown(r.regT);
    if (r.useBr)  return alignDown(r.brT);
    return pc + 32'd4;
  endfunction

  // Memory responder: first request cycle is FETCH, answer arrives after a delay in WAIT.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      reqCycles = 0;
      served    = 1'b0;
      imemReady = 1'b1;
      imemRdata = $urandom;
    end else if (imemReq) begin
      reqCycles++;
      if (reqCycles == 1) begin
        firstAddr = imemAddr;
        respDelay = (forceDelay >= 0) ? forceDelay : int'($urandom_range(0, 5));
        imemReady = 1'b0;
        imemRdata = $urandom;
      end else begin
        checkOutput("addr_hold", {32'd0, imemAddr}, {32'd0, firstAddr});
        if (!served && !holdMem && reqCycles >= 2 + respDelay) begin
          imemRdata = memWord(imemAddr);
          imemReady = 1'b1;
          served    = 1'b1;
          checkOutput("imem_addr", {32'd0, imemAddr}, {32'd0, modelPc});
          expQ.push_back('{word: imemRdata, pc: modelPc});
        end else begin
          imemReady = 1'b0;
          imemRdata = $urandom;
        end
      end
    end else begin
      reqCycles = 0;
      served    = 1'b0;
      imemReady = 1'($urandom_range(0, 1));
      imemRdata = $urandom;
    end
  end

  // Downstream consumer: random back-pressure, redirects from the plan when accepting.
  always @(posedge clk) begin
    redirT r;
    #1;
    if (instrValid) validCycles++;
    else validCycles = 0;
    r.useReg = ($urandom_range(0, 7) == 0);
    r.useBr  = ($urandom_range(0, 3) == 0);
    r.regT   = $urandom;
    r.brT    = $urandom;
    if (reset) begin
      instrReady = 1'b0;
    end else if (instrValid) begin
      if (forceStall > 0 && validCycles <= forceStall) instrReady = 1'b0;
      else instrReady = ($urandom_range(0, 3) != 0);
      if (instrReady && plan.size() > 0) r = plan.pop_front();
    end else begin
      instrReady = 1'($urandom_range(0, 1));
    end
    regToPc      = r.useReg;
    branchTaken  = r.useBr;
    regTarget    = r.regT;
    branchTarget = r.brT;
  end

  // Monitor: compares presented fields with the scoreboard head and steps the model.
  always @(negedge clk) begin
    expT   e;
    redirT r;
    if (!reset) begin
      checkOutput("pc", {32'd0, imemAddr}, {32'd0, modelPc});
      checkOutput("halted", {63'd0, halted}, {63'd0, modelHalted});
      if (modelHalted) begin
        checkOutput("halt_req", {63'd0, imemReq}, 64'd0);
        checkOutput("halt_valid", {63'd0, instrValid}, 64'd0);
      end
      if (instrValid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_issue", {31'd0, pcOut, instrValid}, 64'd0);
        end else begin
          e = expQ[0];
          checkOutput("op_code", {58'd0, opCode}, {58'd0, e.word[31:26]});
          checkOutput("func_code", {53'd0, funcCode}, {53'd0, e.word[10:0]});
          checkOutput("rs_rt", {54'd0, rsOut, rtOut}, {54'd0, e.word[25:16]});
          checkOutput("imm", {48'd0, immOut}, {48'd0, e.word[15:0]});
          checkOutput("pc_out", {32'd0, pcOut}, {32'd0, e.pc});
          if (instrReady) begin
            void'(expQ.pop_front());
            r.useReg = regToPc;
            r.useBr  = branchTaken;
            r.regT   = regTarget;
            r.brT    = branchTarget;
            if (e.word[31:26] == 6'd63) modelHalted = 1'b1;
            else modelPc = refNextPc(e.pc, r);
            accepts++;
          end
        end
      end
    end
  end

  task automatic resetModel();
    expQ.delete();
    plan.delete();
    modelPc     = '0;
    modelHalted = 1'b0;
  endtask

  task automatic applyStimulus(input int nAccepts);
    int target;
    target = accepts + nAccepts;
    for (int c = 0; c < nAccepts * 60 && accepts < target; c++) @(posedge clk);
    if (accepts < target)
      checkOutput("accept_timeout", 64'(accepts), 64'(target));
  endtask

  initial begin
    int cyc;
    #1 reset = 1'b1;
    #2;
    checkOutput("rst_req", {63'd0, imemReq}, 64'd0);
    checkOutput("rst_addr", {32'd0, imemAddr}, 64'd0);
    checkOutput("rst_valid", {63'd0, instrValid}, 64'd0);
    checkOutput("rst_halted", {63'd0, halted}, 64'd0);
    checkOutput("rst_fields", {27'd0, opCode, funcCode, rsOut, rtOut}, 64'd0);
    checkOutput("rst_imm_pc", {16'd0, immOut, pcOut}, 64'd0);
    repeat (3) @(posedge clk);

    $display("[TB] latency and sequential fetch");
    forceDelay = 0;
    resetModel();
    for (int i = 0; i < 3; i++) plan.push_back('{useReg: 0, useBr: 0, regT: 0, brT: 0});
    #2 reset = 1'b0;
    cyc = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (instrValid) break;
    end
    checkOutput("first_valid_cycle", 64'(cyc), 64'd3);
    applyStimulus(3);

    $display("[TB] redirects, alignment, wrap, slow memory, stalls");
    forceDelay = 5;
    forceStall = 4;
    plan.push_back('{useReg: 0, useBr: 1, regT: 32'h0, brT: 32'h40});
    plan.push_back('{useReg: 1, useBr: 1, regT: 32'h80, brT: 32'h44});
    plan.push_back('{useReg: 0, useBr: 1, regT: 32'h0, brT: 32'h43});
    plan.push_back('{useReg: 1, useBr: 0, regT: 32'hFFFF_FFFC, brT: 32'h0});
    plan.push_back('{useReg: 0, useBr: 0, regT: 32'h0, brT: 32'h0});
    applyStimulus(6);
    forceDelay = -1;
    forceStall = 0;
    applyStimulus(40);

    $display("[TB] reset during WAIT");
    holdMem = 1'b1;
    cyc = 0;
    for (int c = 0; c < 200 && cyc < 3; c++) begin
      @(posedge clk);
      #1;
      cyc = imemReq ? cyc + 1 : 0;
    end
    checkOutput("reach_wait", 64'(cyc >= 3), 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midwait_req", {63'd0, imemReq}, 64'd0);
    checkOutput("midwait_addr", {32'd0, imemAddr}, 64'd0);
    checkOutput("midwait_fields", {27'd0, opCode, funcCode, rsOut, rtOut}, 64'd0);
    checkOutput("midwait_pc_out", {32'd0, pcOut}, 64'd0);
    resetModel();
    holdMem = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    applyStimulus(10);

    $display("[TB] halt");
    haltArmed = 1'b1;
    plan.push_back('{useReg: 1, useBr: 0, regT: haltAddr, brT: 32'h0});
    for (int c = 0; c < 400 && !modelHalted; c++) @(posedge clk);
    checkOutput("halt_reached", {63'd0, modelHalted}, 64'd1);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      checkOutput("halted_hold", {62'd0, halted, imemReq}, 64'd2);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
